// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed 4-digit common-anode 7-segment scan driver with shadowed frames,
// anti-ghost blanking, blink and invalid-code dash. Optional macro SEG_LZB_EN adds leading-zero blanking.
module seven_seg_scan_driver #(
    parameter int unsigned CLOCK_FREQ   = 100_000_000,
    parameter int unsigned REFRESH_HZ   = 1000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned BLINK_HZ     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] segments,
    input  logic [3:0]  dp_mask,
    input  logic        blink_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned SCAN_TICK  = CLOCK_FREQ / REFRESH_HZ;
    localparam int unsigned BLINK_HALF = CLOCK_FREQ / (2 * BLINK_HZ);
    localparam int unsigned SLOT_W     = (SCAN_TICK > 1) ? $clog2(SCAN_TICK) : 1;
    localparam int unsigned BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SCAN_TICK - 1);
    localparam logic [SLOT_W-1:0]  VIS_END    = SLOT_W'(SCAN_TICK - BLANK_CYCLES);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    logic [0:0]         state_q;
    logic [1:0]         index_q;
    logic [SLOT_W-1:0]  slot_q;
    logic [BLINK_W-1:0] blink_cnt_q;
    logic               phase_on_q;
    logic [15:0]        shadow_seg_q;
    logic [3:0]         shadow_dp_q;

    logic [3:0] nibble;
    logic [6:0] glyph;
    logic       suppress;
    logic       visible;
    logic [3:0] an_d;
    logic [6:0] seg_d;
    logic       dp_d;

    always_comb begin
        nibble = shadow_seg_q[3:0];
        case (index_q)
            2'd0:    nibble = shadow_seg_q[3:0];
            2'd1:    nibble = shadow_seg_q[7:4];
            2'd2:    nibble = shadow_seg_q[11:8];
            default: nibble = shadow_seg_q[15:12];
        endcase
    end

    // Active-low {g,f,e,d,c,b,a}; non-BCD nibbles show a dash.
    always_comb begin
        glyph = 7'b0111111;
        case (nibble)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = 7'b0111111;
        endcase
    end

`ifdef SEG_LZB_EN
    logic lead3_zero;
    logic lead2_zero;
    assign lead3_zero = (shadow_seg_q[15:12] == 4'd0);
    assign lead2_zero = lead3_zero && (shadow_seg_q[11:8] == 4'd0);
    assign suppress   = ((index_q == 2'd3) && lead3_zero) || ((index_q == 2'd2) && lead2_zero);
`else
    assign suppress = 1'b0;
`endif

    // Dropping blink_en must light the display on the very next output edge.
    assign visible = (state_q == ST_SCAN) && (slot_q < VIS_END) &&
                     (phase_on_q || !blink_en) && !suppress;

    always_comb begin
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
        dp_d  = 1'b1;
        if (visible) begin
            an_d  = ~(4'b0001 << index_q);
            seg_d = glyph;
            dp_d  = ~shadow_dp_q[index_q];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_LOAD;
            index_q      <= 2'd0;
            slot_q       <= '0;
            shadow_seg_q <= 16'h0000;
            shadow_dp_q  <= 4'h0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    shadow_seg_q <= segments;
                    shadow_dp_q  <= dp_mask;
                    state_q      <= ST_SCAN;
                end
                default: begin
                    if (slot_q == SLOT_LAST) begin
                        slot_q  <= '0;
                        index_q <= index_q + 2'd1;
                        // Reload only on frame wrap so a frame never mixes two input words.
                        if (index_q == 2'd3) begin
                            shadow_seg_q <= segments;
                            shadow_dp_q  <= dp_mask;
                        end
                    end else begin
                        slot_q <= slot_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_q <= '0;
            phase_on_q  <= 1'b1;
        end else if (!blink_en) begin
            blink_cnt_q <= '0;
            phase_on_q  <= 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q <= '0;
            phase_on_q  <= ~phase_on_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver: per-digit vector table plus reset, reload,
// blink and asynchronous-reset sequences. Follows SEG_LZB_EN when defined.
module tb_seven_seg_scan_driver;

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] segments = 16'h0000;
    logic [3:0]  dp_mask = 4'h0;
    logic        blink_en = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks = 0;
    int fails  = 0;

    seven_seg_scan_driver #(
        .CLOCK_FREQ  (1000),
        .REFRESH_HZ  (100),
        .BLANK_CYCLES(2),
        .BLINK_HZ    (10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .segments(segments),
        .dp_mask (dp_mask),
        .blink_en(blink_en),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] segs;
        logic [3:0]  dpm;
        int          digit;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
    } vec_t;

    vec_t vecs[19];
    int   nvec = 0;

    task automatic add_vec(input logic [15:0] s, input logic [3:0] m, input int d,
                           input logic [3:0] ea, input logic [6:0] es, input logic ed);
        vecs[nvec].segs  = s;
        vecs[nvec].dpm   = m;
        vecs[nvec].digit = d;
        vecs[nvec].an    = ea;
        vecs[nvec].seg   = es;
        vecs[nvec].dp    = ed;
        nvec++;
    endtask

    task automatic check(input string name, input logic [3:0] ea, input logic [6:0] es,
                         input logic ed);
        checks++;
        if (an !== ea || seg !== es || dp !== ed) begin
            fails++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                     name, an, seg, dp, ea, es, ed);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves reset released at a negedge; the next posedge is the LOAD cycle.
    task automatic do_reset(input logic [15:0] s, input logic [3:0] m);
        reset    = 1'b1;
        segments = s;
        dp_mask  = m;
        blink_en = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        add_vec(16'h1234, 4'b0000, 0, 4'b1110, 7'b0011001, 1'b1);
        add_vec(16'h1234, 4'b0000, 1, 4'b1101, 7'b0110000, 1'b1);
        add_vec(16'h1234, 4'b0000, 2, 4'b1011, 7'b0100100, 1'b1);
        add_vec(16'h1234, 4'b0000, 3, 4'b0111, 7'b1111001, 1'b1);
        add_vec(16'h0A25, 4'b0100, 0, 4'b1110, 7'b0010010, 1'b1);
        add_vec(16'h0A25, 4'b0100, 1, 4'b1101, 7'b0100100, 1'b1);
        add_vec(16'h0A25, 4'b0100, 2, 4'b1011, 7'b0111111, 1'b0);
        add_vec(16'h6789, 4'b1111, 0, 4'b1110, 7'b0010000, 1'b0);
        add_vec(16'h6789, 4'b1111, 1, 4'b1101, 7'b0000000, 1'b0);
        add_vec(16'h6789, 4'b1111, 2, 4'b1011, 7'b1111000, 1'b0);
        add_vec(16'h6789, 4'b1111, 3, 4'b0111, 7'b0000010, 1'b0);
        add_vec(16'h0007, 4'b0000, 0, 4'b1110, 7'b1111000, 1'b1);
        add_vec(16'h0007, 4'b0000, 1, 4'b1101, 7'b1000000, 1'b1);
        add_vec(16'hF0B0, 4'b1000, 3, 4'b0111, 7'b0111111, 1'b0);
        add_vec(16'hF0B0, 4'b1000, 1, 4'b1101, 7'b0111111, 1'b1);
`ifdef SEG_LZB_EN
        add_vec(16'h0A25, 4'b0100, 3, AN_OFF, SEG_OFF, 1'b1);
        add_vec(16'h0007, 4'b0000, 2, AN_OFF, SEG_OFF, 1'b1);
        add_vec(16'h0007, 4'b0000, 3, AN_OFF, SEG_OFF, 1'b1);
        add_vec(16'h00C0, 4'b0100, 2, AN_OFF, SEG_OFF, 1'b1);
`else
        add_vec(16'h0A25, 4'b0100, 3, 4'b0111, 7'b1000000, 1'b1);
        add_vec(16'h0007, 4'b0000, 2, 4'b1011, 7'b1000000, 1'b1);
        add_vec(16'h0007, 4'b0000, 3, 4'b0111, 7'b1000000, 1'b1);
        add_vec(16'h00C0, 4'b0100, 2, 4'b1011, 7'b1000000, 1'b0);
`endif

        // Reset state and first-frame timing.
        segments = 16'h1234;
        step(1);
        check("reset_dark", AN_OFF, SEG_OFF, 1'b1);
        reset = 1'b0;
        step(1);
        check("load_dark", AN_OFF, SEG_OFF, 1'b1);
        step(1);
        check("first_digit0", 4'b1110, 7'b0011001, 1'b1);
        for (int k = 1; k < 10; k++) begin
            step(1);
            if (k < 8) check("slot_visible", 4'b1110, 7'b0011001, 1'b1);
            else       check("slot_blank", AN_OFF, SEG_OFF, 1'b1);
        end
        step(1);
        check("digit1_start", 4'b1101, 7'b0110000, 1'b1);

        // Per-digit decode, dp and suppression vectors, sampled mid-slot.
        for (int i = 0; i < nvec; i++) begin
            do_reset(vecs[i].segs, vecs[i].dpm);
            step(2 + vecs[i].digit * 10 + 3);
            check($sformatf("vec%0d_%h_d%0d", i, vecs[i].segs, vecs[i].digit),
                  vecs[i].an, vecs[i].seg, vecs[i].dp);
        end

        // Tear-free reload: change input during digit 1.
        do_reset(16'h1234, 4'b0000);
        step(2 + 13);
        segments = 16'h5678;
        step(10);
        check("tear_d2_old", 4'b1011, 7'b0100100, 1'b1);
        step(10);
        check("tear_d3_old", 4'b0111, 7'b1111001, 1'b1);
        step(10);
        check("tear_d0_new", 4'b1110, 7'b0000000, 1'b1);
        step(10);
        check("tear_d1_new", 4'b1101, 7'b1111000, 1'b1);

        // Blink: enabled right after the first visible output edge.
        do_reset(16'h1234, 4'b0000);
        step(2);
        blink_en = 1'b1;
        for (int k = 1; k <= 161; k++) begin
            step(1);
            if (k == 1)                 check("blink_on_first", 4'b1110, 7'b0011001, 1'b1);
            if (k == 50)                check("blink_on_last", 4'b1101, 7'b0110000, 1'b1);
            if (k >= 51 && k <= 100)    check("blink_off", AN_OFF, SEG_OFF, 1'b1);
            if (k == 101)               check("blink_on_again", 4'b1011, 7'b0100100, 1'b1);
            if (k == 150)               check("blink_on2_last", 4'b0111, 7'b1111001, 1'b1);
            if (k == 151 || k == 160)   check("blink_off2", AN_OFF, SEG_OFF, 1'b1);
            if (k == 160)               blink_en = 1'b0;
            if (k == 161)               check("blink_drop", 4'b1110, 7'b0011001, 1'b1);
        end

        // Asynchronous reset mid-slot, restart with the new inputs.
        do_reset(16'h1234, 4'b0000);
        step(2 + 135);
        check("pre_async", 4'b1101, 7'b0110000, 1'b1);
        #2 reset = 1'b1;
        #1 check("async_dark", AN_OFF, SEG_OFF, 1'b1);
        segments = 16'h4321;
        step(1);
        reset = 1'b0;
        step(1);
        check("async_load_dark", AN_OFF, SEG_OFF, 1'b1);
        step(1);
        check("async_restart_d0", 4'b1110, 7'b1111001, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
